multicycle_adder: RTL and testbench

//   Parametrised multi-cycle add/subtract unit. Processes a WIDTH-bit operand pair

---
 rtl/multicycle_adder_pkg.sv | 9 +
 rtl/chunk_adder.sv | 26 ++
 rtl/multicycle_adder.sv | 121 ++++++++++++
 tb/tb_multicycle_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_adder_pkg.sv
// Shared types and opcode constants for the multi-cycle add/subtract unit.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} madd_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple of CHUNK full-adder cells; zero latency, no flow control.
// Also exposes the carry into the MSB cell so the caller can derive signed overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o     = carry[CHUNK];
  assign c_msb_o = carry[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// Add/subtract WIDTH bits CHUNK bits per cycle; result valid WIDTH/CHUNK cycles after accept.
// Accepts only in IDLE; result holds in DONE until ready_i, which stalls the next accept.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ovf_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_chk
    $error("multicycle_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  madd_state_t state_q, state_d;

  logic [WIDTH-1:0] x_q, y_q, acc_q, acc_d, s_q, sum_ext;
  logic [CNT_W-1:0] cnt_q;
  logic             sub_q, cy_q, c_q, ovf_q;
  logic [CHUNK-1:0] sum;
  logic             cy_nxt, cy_msb, last_chunk;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (x_q[CHUNK-1:0]),
    .b_i     (y_q[CHUNK-1:0]),
    .c_i     (cy_q),
    .s_o     (sum),
    .c_o     (cy_nxt),
    .c_msb_o (cy_msb)
  );

  // New chunk enters the result shift register at the top, older chunks move down.
  always_comb begin
    sum_ext              = '0;
    sum_ext[CHUNK-1:0]   = sum;
    acc_d                = (acc_q >> CHUNK) | (sum_ext << (WIDTH - CHUNK));
  end

  assign last_chunk = (state_q == BUSY) && (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i)    state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (ready_i)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      s_q   <= '0;
      cnt_q <= '0;
      sub_q <= 1'b0;
      cy_q  <= 1'b0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            x_q   <= x_i;
            y_q   <= (sub_i == OP_SUB) ? ~y_i : y_i;
            sub_q <= sub_i;
            cy_q  <= (sub_i == OP_ADD) ? c_i : ~c_i;
            cnt_q <= '0;
          end
        end
        BUSY: begin
          x_q   <= x_q >> CHUNK;
          y_q   <= y_q >> CHUNK;
          cy_q  <= cy_nxt;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_chunk) begin
            s_q   <= acc_d;
            c_q   <= cy_nxt ^ (sub_q == OP_SUB);
            ovf_q <= cy_msb ^ cy_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_o   = s_q;
  assign c_o   = c_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed checks on an 8/2 instance plus randomized runs on four WIDTH/CHUNK configurations.
module tb_multicycle_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input longint x, input longint y,
                                input bit c, input bit sub,
                                output longint s, output bit co, output bit ov);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint sx   = (x >= half) ? x - (half << 1) : x;
    longint sy   = (y >= half) ? y - (half << 1) : y;
    longint r, sr;
    if (!sub) begin
      r  = x + y + longint'(c);
      sr = sx + sy + longint'(c);
      co = (r > m);
    end else begin
      r  = x - y - longint'(c);
      sr = sx - sy - longint'(c);
      co = (r < 0);
    end
    s  = r & m;
    ov = (sr >= half) || (sr < -half);
  endfunction

  // Directed instance, WIDTH=8 CHUNK=2
  logic       d_rst, d_valid, d_ready_o, d_c, d_sub, d_valid_o, d_ready_i, d_c_o, d_ovf_o;
  logic [7:0] d_x, d_y, d_s_o;
  logic       rst_r;

  multicycle_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk_i(clk), .rst_i(d_rst), .valid_i(d_valid), .ready_o(d_ready_o),
    .x_i(d_x), .y_i(d_y), .c_i(d_c), .sub_i(d_sub),
    .valid_o(d_valid_o), .ready_i(d_ready_i), .s_o(d_s_o), .c_o(d_c_o), .ovf_o(d_ovf_o)
  );

  task automatic d_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic sub, output int lat);
    int guard = 0;
    while (!d_ready_o && guard < 50) begin @(negedge clk); guard++; end
    check_val("d_launch_rdy", d_ready_o, 1);
    d_x = x; d_y = y; d_c = c; d_sub = sub; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    lat = 0;
    while (!d_valid_o && lat < 50) begin
      check_val("d_busy_rdy", d_ready_o, 0);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic d_expect(input string tag, input int lat, input longint s,
                          input bit co, input bit ov);
    check_val({tag, "_lat"}, lat, 4);
    check_val({tag, "_s"},   d_s_o, s);
    check_val({tag, "_c"},   d_c_o, co);
    check_val({tag, "_ovf"}, d_ovf_o, ov);
  endtask

  // Randomized instances
  for (genvar g = 0; g < 4; g++) begin : g_rand
    localparam int W = (g == 3) ? 32 : 8;
    localparam int C = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 4;
    localparam int N = W / C;

    logic         valid_i, ready_o, c_i, sub_i, valid_o, ready_i, c_o, ovf_o;
    logic [W-1:0] x_i, y_i, s_o;
    bit           done_b = 1'b0;

    multicycle_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk_i(clk), .rst_i(rst_r), .valid_i(valid_i), .ready_o(ready_o),
      .x_i(x_i), .y_i(y_i), .c_i(c_i), .sub_i(sub_i),
      .valid_o(valid_o), .ready_i(ready_i), .s_o(s_o), .c_o(c_o), .ovf_o(ovf_o)
    );

    initial begin
      longint mask, xr, yr, es;
      bit     cr, sr, ec, eo;
      int     lat, guard;
      mask = (longint'(1) << W) - 1;
      valid_i = 1'b0; ready_i = 1'b0; x_i = '0; y_i = '0; c_i = 1'b0; sub_i = 1'b0;
      @(negedge clk);
      while (rst_r) @(negedge clk);
      for (int op = 0; op < 500; op++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        xr = longint'($urandom) & mask;
        yr = longint'($urandom) & mask;
        if ($urandom_range(0, 7) == 0) xr = mask;
        if ($urandom_range(0, 7) == 0) yr = longint'(1) << (W - 1);
        cr = 1'($urandom_range(0, 1));
        sr = 1'($urandom_range(0, 1));
        model(W, xr, yr, cr, sr, es, ec, eo);
        guard = 0;
        while (!ready_o && guard < 50) begin @(negedge clk); guard++; end
        check_val("r_launch_rdy", ready_o, 1);
        x_i = xr[W-1:0]; y_i = yr[W-1:0]; c_i = cr; sub_i = sr; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 50) begin @(negedge clk); lat++; end
        check_val("r_lat", lat, N);
        check_val("r_c",   c_o, ec);
        check_val("r_ovf", ovf_o, eo);
        guard = 0;
        while (valid_o && guard < 50) begin
          check_val("r_s", s_o, es);
          ready_i = 1'($urandom_range(0, 1));
          valid_i = 1'($urandom_range(0, 1));
          x_i     = W'($urandom);
          @(negedge clk);
          guard++;
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        check_val("r_idle_rdy", ready_o, 1);
      end
      done_b = 1'b1;
    end
  end

  initial begin
    int lat, guard;
    bit all_done;
    d_rst = 1'b1; rst_r = 1'b1; d_valid = 1'b0; d_ready_i = 1'b1;
    d_x = '0; d_y = '0; d_c = 1'b0; d_sub = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", d_ready_o, 1);
    check_val("rst_valid", d_valid_o, 0);
    check_val("rst_s",     d_s_o, 0);
    check_val("rst_c",     d_c_o, 0);
    check_val("rst_ovf",   d_ovf_o, 0);
    d_rst = 1'b0; rst_r = 1'b0;

    d_op(8'h7F, 8'h01, 1'b0, 1'b0, lat); d_expect("t1_add", lat, 'h80, 0, 1);
    d_op(8'h10, 8'h20, 1'b0, 1'b1, lat); d_expect("t2_sub", lat, 'hF0, 1, 0);
    d_op(8'h80, 8'h01, 1'b0, 1'b1, lat); d_expect("t2_subovf", lat, 'h7F, 0, 1);
    d_op(8'hFF, 8'h01, 1'b1, 1'b0, lat); d_expect("t3_addc", lat, 'h01, 1, 0);
    @(negedge clk);
    check_val("t3_next_valid", d_valid_o, 0);
    check_val("t3_next_ready", d_ready_o, 1);

    d_ready_i = 1'b0;
    d_op(8'h12, 8'h34, 1'b0, 1'b0, lat); d_expect("t4_bp", lat, 'h46, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check_val("t4_hold_valid", d_valid_o, 1);
      check_val("t4_hold_s",     d_s_o, 'h46);
      check_val("t4_hold_ready", d_ready_o, 0);
      d_valid = (i == 4);
      d_x = 8'h01; d_y = 8'h01;
      @(negedge clk);
    end
    d_valid = 1'b0;
    d_ready_i = 1'b1;
    @(negedge clk);
    check_val("t4_rel_valid", d_valid_o, 0);
    check_val("t4_rel_ready", d_ready_o, 1);
    @(negedge clk);
    check_val("t4_no_accept", d_ready_o, 1);

    d_x = 8'hAA; d_y = 8'h11; d_c = 1'b0; d_sub = 1'b0; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    @(negedge clk);
    d_rst = 1'b1;
    @(negedge clk);
    d_rst = 1'b0;
    check_val("t5_rst_valid", d_valid_o, 0);
    check_val("t5_rst_ready", d_ready_o, 1);
    check_val("t5_rst_s",     d_s_o, 0);
    d_op(8'h03, 8'h04, 1'b0, 1'b0, lat); d_expect("t5_after", lat, 'h07, 0, 0);

    guard = 0;
    all_done = 1'b0;
    while (!all_done && guard < 80000) begin
      @(negedge clk);
      guard++;
      all_done = g_rand[0].done_b && g_rand[1].done_b && g_rand[2].done_b && g_rand[3].done_b;
    end
    check_val("rand_complete", all_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
